onehot_pattern_decoder: RTL

Receive-side counterpart of the one-hot up/down pattern FSM: samples its NUM_OF_BITS-wide output bus every clock and recovers the input bit (plain one-hot = 1, inverted one-hot = 0) and the transmitter state index. It tracks the expected state sequence (pos+1 on bit 1, pos-1 on bit 0, mod NUM_OF_BITS), acquires lock, and flags and counts sequence violations. It sits at the far end of the link as a link monitor and data recovery stage.

---
 rtl/onehot_link_pkg.sv | 25 ++
 rtl/onehot_classifier.sv | 40 ++++
 rtl/onehot_pattern_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/onehot_link_pkg.sv
// Shared definitions for the one-hot up/down pattern link (transmitter and receiver side).
//   state_e  : receiver lock FSM states
//   pos_w()  : width of a state index for an N-bit pattern bus, never below 1
//   mod_inc(), mod_dec() : explicit mod-N step; N need not be a power of two
package onehot_link_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  function automatic int unsigned pos_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned mod_inc(input int unsigned pos, input int unsigned n);
    return (pos >= n - 1) ? 0 : pos + 1;
  endfunction

  function automatic int unsigned mod_dec(input int unsigned pos, input int unsigned n);
    return (pos == 0) ? n - 1 : pos - 1;
  endfunction

endpackage

// File: rtl/onehot_classifier.sv
// Combinational classifier for one word of the one-hot link.
//   i_pat   : NUM_OF_BITS-wide pattern word
//   o_legal : word is one-hot (bit 1) or inverted one-hot (bit 0)
//   o_bit   : recovered input bit (1 = plain one-hot)
//   o_pos   : recovered state index; the MSB maps to index 0
module onehot_classifier
  import onehot_link_pkg::*;
#(
  parameter  int unsigned NUM_OF_BITS = 4,
  localparam int unsigned POS_W       = pos_w(NUM_OF_BITS)
) (
  input  logic [NUM_OF_BITS-1:0] i_pat,
  output logic                   o_legal,
  output logic                   o_bit,
  output logic [POS_W-1:0]       o_pos
);

  always_comb begin
    int unsigned v_ones;
    int unsigned v_set_idx;
    int unsigned v_clr_idx;
    v_ones    = 0;
    v_set_idx = 0;
    v_clr_idx = 0;
    for (int unsigned i = 0; i < NUM_OF_BITS; i++) begin
      if (i_pat[i]) begin
        v_ones    = v_ones + 1;
        v_set_idx = i;
      end else begin
        v_clr_idx = i;
      end
    end
    o_legal = (v_ones == 1) || (v_ones == NUM_OF_BITS - 1);
    o_bit   = (v_ones == 1);
    // Index positions are counted from the MSB.
    o_pos   = o_bit ? POS_W'(NUM_OF_BITS - 1 - v_set_idx)
                    : POS_W'(NUM_OF_BITS - 1 - v_clr_idx);
  end

endmodule

// File: rtl/onehot_pattern_decoder.sv
// Receive-side decoder / link monitor for the one-hot up/down pattern link.
// Recovers bit and state index from each sampled word (1-cycle latency), tracks the expected
// index sequence, acquires and loses lock, and flags/counts sequence errors while locked.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   PatIn        : sampled pattern word
//   ClearErr     : synchronous clear of ErrCount (wins over a same-cycle error)
//   DecValid     : registered word was legal
//   DecBit/DecPos: recovered bit / index of the last legal word
//   Locked       : FSM in locked state
//   ErrPulse     : one-cycle pulse per error while locked
//   ErrCount     : saturating error count
module onehot_pattern_decoder
  import onehot_link_pkg::*;
#(
  parameter  int unsigned NUM_OF_BITS = 4,
  parameter  int unsigned LOCK_CNT    = 3,
  parameter  int unsigned LOSS_CNT    = 2,
  parameter  int unsigned CNT_W       = 8,
  localparam int unsigned POS_W       = pos_w(NUM_OF_BITS)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [NUM_OF_BITS-1:0] PatIn,
  input  logic                   ClearErr,
  output logic                   DecValid,
  output logic                   DecBit,
  output logic [POS_W-1:0]       DecPos,
  output logic                   Locked,
  output logic                   ErrPulse,
  output logic [CNT_W-1:0]       ErrCount
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);

  logic             w_legal, w_bit, w_match, w_err;
  logic [POS_W-1:0] w_pos, w_exp;

  state_e            r_state, w_state_nxt;
  logic [POS_W-1:0]  r_anchor_pos, w_anchor_pos_nxt;
  logic              r_anchor_bit, w_anchor_bit_nxt;
  logic [GOOD_W-1:0] r_good, w_good_nxt;
  logic [MISS_W-1:0] r_miss, w_miss_nxt;
  logic              r_dec_valid, r_dec_bit, r_err_pulse;
  logic [POS_W-1:0]  r_dec_pos;
  logic [CNT_W-1:0]  r_err_cnt, w_err_cnt_nxt;

  onehot_classifier #(
    .NUM_OF_BITS(NUM_OF_BITS)
  ) u_classifier (
    .i_pat  (PatIn),
    .o_legal(w_legal),
    .o_bit  (w_bit),
    .o_pos  (w_pos)
  );

  // Only the next index is predicted; the received bit is free to change.
  assign w_exp   = r_anchor_bit ? POS_W'(mod_inc(32'(r_anchor_pos), NUM_OF_BITS))
                                : POS_W'(mod_dec(32'(r_anchor_pos), NUM_OF_BITS));
  assign w_match = w_legal && (w_pos == w_exp);

  always_comb begin
    w_state_nxt      = r_state;
    w_anchor_pos_nxt = r_anchor_pos;
    w_anchor_bit_nxt = r_anchor_bit;
    w_good_nxt       = r_good;
    w_miss_nxt       = r_miss;
    w_err            = 1'b0;
    unique case (r_state)
      StHunt: begin
        if (w_legal) begin
          w_anchor_pos_nxt = w_pos;
          w_anchor_bit_nxt = w_bit;
          w_good_nxt       = GOOD_W'(1);
          w_miss_nxt       = '0;
          w_state_nxt      = (LOCK_CNT == 1) ? StLocked : StVerify;
        end
      end
      StVerify: begin
        if (w_match) begin
          w_anchor_pos_nxt = w_pos;
          w_anchor_bit_nxt = w_bit;
          if (32'(r_good) + 1 >= LOCK_CNT) begin
            w_state_nxt = StLocked;
            w_miss_nxt  = '0;
          end else begin
            w_good_nxt = r_good + GOOD_W'(1);
          end
        end else if (w_legal) begin
          w_anchor_pos_nxt = w_pos;
          w_anchor_bit_nxt = w_bit;
          w_good_nxt       = GOOD_W'(1);
        end else begin
          w_state_nxt = StHunt;
        end
      end
      StLocked: begin
        if (w_match) begin
          w_anchor_pos_nxt = w_pos;
          w_anchor_bit_nxt = w_bit;
          w_miss_nxt       = '0;
        end else begin
          w_err = 1'b1;
          // A legal but unexpected word becomes the new reference point.
          if (w_legal) begin
            w_anchor_pos_nxt = w_pos;
            w_anchor_bit_nxt = w_bit;
          end
          if (32'(r_miss) + 1 >= LOSS_CNT) begin
            w_state_nxt = StHunt;
            w_miss_nxt  = '0;
            w_good_nxt  = '0;
          end else begin
            w_miss_nxt = r_miss + MISS_W'(1);
          end
        end
      end
      default: w_state_nxt = StHunt;
    endcase
  end

  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (ClearErr) begin
      w_err_cnt_nxt = '0;
    end else if (w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= StHunt;
      r_anchor_pos <= '0;
      r_anchor_bit <= 1'b0;
      r_good       <= '0;
      r_miss       <= '0;
      r_dec_valid  <= 1'b0;
      r_dec_bit    <= 1'b0;
      r_dec_pos    <= '0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_anchor_pos <= w_anchor_pos_nxt;
      r_anchor_bit <= w_anchor_bit_nxt;
      r_good       <= w_good_nxt;
      r_miss       <= w_miss_nxt;
      r_dec_valid  <= w_legal;
      r_err_pulse  <= w_err;
      r_err_cnt    <= w_err_cnt_nxt;
      if (w_legal) begin
        r_dec_bit <= w_bit;
        r_dec_pos <= w_pos;
      end
    end
  end

  assign DecValid = r_dec_valid;
  assign DecBit   = r_dec_bit;
  assign DecPos   = r_dec_pos;
  assign Locked   = (r_state == StLocked);
  assign ErrPulse = r_err_pulse;
  assign ErrCount = r_err_cnt;

endmodule
